matrix_multiplier: RTL and testbench
====================================

Name: matrix_multiplier

Overview:
- Precoding block: multiplies a streamed 4x4 complex channel matrix H by a 4x2 complex precoder S selected by q_index, producing Hq = H x S.
- All samples are signed fixed point, Q fractional bits (default Q8.8).
- Sits between channel estimation and the precoder-selection metric; outputs stream out row-major.

Parameters:
- Q, 8, number of fractional bits in all samples.
- N, 16, sample width (signed) for each real/imag component.
- ACC_WIDTH, 32, signed accumulator width for the complex MAC.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a job and latches q_index.
- H_in_valid  input  1  qualifies H_in_r/H_in_i.
- H_in_r  input  N  signed real part of an H element.
- H_in_i  input  N  signed imaginary part of an H element.
- q_index  input  4  precoder selector; sampled only with start.
- done  output  1  level; high from job completion until the next accepted start.
- Hq_out_valid  output  1  one-cycle qualifier for each Hq element.
- Hq_out_r  output  N  signed real part of an Hq element.
- Hq_out_i  output  N  signed imaginary part of an Hq element.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE; done, Hq_out_valid, Hq_out_r and Hq_out_i all go to 0; the H buffer and counters clear. Reset mid-job aborts the job.
- FSM states: IDLE -> LOAD -> CALC -> DONE; DONE -> LOAD on start.
- IDLE/DONE:
  - start=1 latches q_index, clears done and enters LOAD.
  - start is ignored in LOAD and CALC.
- LOAD:
  - Every cycle with H_in_valid=1 stores one element into H[row][col], in row-major order (row 0 col 0..3, then row 1, ...).
  - Idle gaps in H_in_valid are allowed.
  - H_in_valid outside LOAD is ignored.
  - After the 16th element, go to CALC.
- S codebook, in Q8.8 (+0.5 = 128, -0.5 = -128):
  - q_index=0: S real = [[+.5,+.5],[-.5,+.5],[+.5,+.5],[-.5,+.5]], imaginary all 0.
  - q_index 1..15: reserved; S = all zero.
- CALC computes the 8 outputs in order (0,0),(0,1),(1,0),...,(3,1). Each output takes 4 MAC cycles over k=0..3, then 1 emit cycle.
- MAC per term:
  - re += Hr*Sr - Hi*Si
  - im += Hr*Si + Hi*Sr
  - Products are full 2N-bit; accumulation is in ACC_WIDTH, holding 2Q fractional bits.
- Emit:
  - Result = acc >>> Q (arithmetic shift, truncation toward -inf).
  - Result saturates to the signed N-bit range [-2^(N-1), 2^(N-1)-1].
  - Hq_out_valid=1 for exactly one cycle.
- Cadence: valid pulses are 5 cycles apart, never back-to-back. The first pulse comes 5 cycles after the 16th H element is accepted.
- Hq_out_r/Hq_out_i hold their last emitted value while valid is low.
- done rises the cycle after the 8th valid pulse and holds until the next start; the FSM is then in DONE.
- Simultaneous start and H_in_valid in IDLE/DONE: the H sample is ignored. The H stream begins on the following cycle.

Decomposition:
- Shared package (matrix_multiplier_pkg):
  - Default Q/N/ACC_WIDTH.
  - State enum {IDLE, LOAD, CALC, DONE}.
  - Codebook constants P_HALF=128, N_HALF=-128, ZERO.
  - S lookup function, (q_index, k, j) -> {Sr, Si}.
- One natural sub-module: complex_mac, containing the complex multiply, the accumulate/clear logic, and the shift and saturate on emit.

Test Plan:
- H = identity (diagonal real 256, all else 0), q=0 -> outputs row-major (r,i): (128,0),(128,0); (-128,0),(128,0); (128,0),(128,0); (-128,0),(128,0).
- Same H, q=1 -> all 8 outputs (0,0); done asserts and holds.
- H real all 256, imag 0, q=0 -> each row (0,0),(512,0). H imag all 256, real 0, q=0 -> each row (0,0),(0,512).
- H real all 0x7FFF, q=0 -> column 1 saturates to 0x7FFF; column 0 = 0.
- H_in_valid with random idle gaps, then a start pulse during CALC -> results identical to the gap-free run; the mid-job start is ignored. Check the 5-cycle valid spacing.
- Assert rst mid-LOAD -> outputs/done 0 immediately; a fresh job with identity H, q=0 gives the first scenario's results.

Source files
------------

// File: rtl/matrix_multiplier_pkg.sv
// Shared defaults, FSM state type and the precoder codebook for matrix_multiplier.
package matrix_multiplier_pkg;

    localparam int DEF_Q         = 8;
    localparam int DEF_N         = 16;
    localparam int DEF_ACC_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    // Codebook entries in Q8.8
    localparam logic signed [DEF_N-1:0] P_HALF = 16'sd128;
    localparam logic signed [DEF_N-1:0] N_HALF = -16'sd128;
    localparam logic signed [DEF_N-1:0] ZERO   = '0;

    typedef struct packed {
        logic signed [DEF_N-1:0] sr;
        logic signed [DEF_N-1:0] si;
    } s_elem_t;

    // S[k][j] for the selected precoder; reserved indices give an all-zero matrix.
    // q=0: column 1 is +0.5 everywhere, column 0 alternates +0.5/-0.5 down the rows.
    function automatic s_elem_t s_lookup(input logic [3:0] q, input logic [1:0] k, input logic j);
        s_elem_t s;
        s.sr = ZERO;
        s.si = ZERO;
        if (q == 4'd0) begin
            if (j) s.sr = P_HALF;
            else   s.sr = k[0] ? N_HALF : P_HALF;
        end
        return s;
    endfunction

endpackage

// File: rtl/matrix_multiplier_complex_mac.sv
// Complex multiply-accumulate with truncating shift and saturation on emit.
module complex_mac
    import matrix_multiplier_pkg::*;
#(
    parameter int Q         = DEF_Q,
    parameter int N         = DEF_N,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mac_en,
    input  logic                first,
    input  logic                emit,
    input  logic signed [N-1:0] a_r,
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_r,
    input  logic signed [N-1:0] b_i,
    output logic signed [N-1:0] out_r,
    output logic signed [N-1:0] out_i,
    output logic                out_valid
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (N - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (N - 1)));

    logic signed [2*N-1:0]       p_rr, p_ii, p_ri, p_ir;
    logic signed [ACC_WIDTH-1:0] term_re, term_im;
    logic signed [ACC_WIDTH-1:0] acc_re, acc_im;

    function automatic logic signed [N-1:0] shift_sat(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] shifted;
        shifted = acc >>> Q;
        if (shifted > SAT_MAX)      return N'(SAT_MAX);
        else if (shifted < SAT_MIN) return N'(SAT_MIN);
        else                        return N'(shifted);
    endfunction

    // Full-width products combined into one complex term per cycle
    always_comb begin
        p_rr    = a_r * b_r;
        p_ii    = a_i * b_i;
        p_ri    = a_r * b_i;
        p_ir    = a_i * b_r;
        term_re = ACC_WIDTH'(p_rr) - ACC_WIDTH'(p_ii);
        term_im = ACC_WIDTH'(p_ri) + ACC_WIDTH'(p_ir);
    end

    // Accumulator: first term of an output overwrites instead of adding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (mac_en) begin
            acc_re <= first ? term_re : acc_re + term_re;
            acc_im <= first ? term_im : acc_im + term_im;
        end
    end

    // Output register: holds the last emitted value, valid pulses for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r     <= '0;
            out_i     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                out_r <= shift_sat(acc_re);
                out_i <= shift_sat(acc_im);
            end
        end
    end

endmodule

// File: rtl/matrix_multiplier.sv
// Hq = H x S: buffers a streamed 4x4 complex H, then emits 8 Hq elements row-major.
module matrix_multiplier
    import matrix_multiplier_pkg::*;
#(
    parameter int Q         = DEF_Q,
    parameter int N         = DEF_N,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                H_in_valid,
    input  logic signed [N-1:0] H_in_r,
    input  logic signed [N-1:0] H_in_i,
    input  logic [3:0]          q_index,
    output logic                done,
    output logic                Hq_out_valid,
    output logic signed [N-1:0] Hq_out_r,
    output logic signed [N-1:0] Hq_out_i
);

    state_t state, state_next;

    logic [3:0]          load_cnt;
    logic [2:0]          step;
    logic [2:0]          out_idx;
    logic [3:0]          q_reg;
    logic signed [N-1:0] h_r [16];
    logic signed [N-1:0] h_i [16];

    logic                accept_start;
    logic                mac_en, mac_first, mac_emit;
    logic [1:0]          k;
    logic [3:0]          h_idx;
    s_elem_t             s_sel;
    logic signed [N-1:0] s_r, s_i;

    assign accept_start = start && ((state == IDLE) || (state == DONE));
    assign k            = step[1:0];
    assign h_idx        = {out_idx[2:1], k};
    assign s_sel        = s_lookup(q_reg, k, out_idx[0]);
    assign s_r          = N'(s_sel.sr);
    assign s_i          = N'(s_sel.si);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state and MAC sequencing: 4 MAC steps then 1 emit step per output
    always_comb begin
        state_next = state;
        mac_en     = 1'b0;
        mac_first  = 1'b0;
        mac_emit   = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_next = LOAD;
            LOAD:       if (H_in_valid && (load_cnt == 4'd15)) state_next = CALC;
            CALC: begin
                mac_en    = (step != 3'd4);
                mac_first = (step == 3'd0);
                mac_emit  = (step == 3'd4);
                if ((step == 3'd4) && (out_idx == 3'd7)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // H buffer, load/calc counters and latched precoder index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt <= '0;
            step     <= '0;
            out_idx  <= '0;
            q_reg    <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                h_r[i] <= '0;
                h_i[i] <= '0;
            end
        end else begin
            if (accept_start) begin
                q_reg    <= q_index;
                load_cnt <= '0;
                step     <= '0;
                out_idx  <= '0;
            end
            if ((state == LOAD) && H_in_valid) begin
                h_r[load_cnt] <= H_in_r;
                h_i[load_cnt] <= H_in_i;
                load_cnt      <= load_cnt + 4'd1;
            end
            if (state == CALC) begin
                if (step == 3'd4) begin
                    step    <= '0;
                    out_idx <= out_idx + 3'd1;
                end else begin
                    step <= step + 3'd1;
                end
            end
        end
    end

    // done is registered off DONE so it rises one cycle after the last valid pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               done <= 1'b0;
        else if (accept_start)  done <= 1'b0;
        else if (state == DONE) done <= 1'b1;
    end

    complex_mac #(
        .Q         (Q),
        .N         (N),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .mac_en    (mac_en),
        .first     (mac_first),
        .emit      (mac_emit),
        .a_r       (h_r[h_idx]),
        .a_i       (h_i[h_idx]),
        .b_r       (s_r),
        .b_i       (s_i),
        .out_r     (Hq_out_r),
        .out_i     (Hq_out_i),
        .out_valid (Hq_out_valid)
    );

endmodule

// File: tb/tb_matrix_multiplier.sv
// Scoreboard bench for matrix_multiplier: driver pushes expected Hq, monitor pops on valid.
module tb_matrix_multiplier;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               H_in_valid;
    logic signed [15:0] H_in_r, H_in_i;
    logic [3:0]         q_index;
    logic               done;
    logic               Hq_out_valid;
    logic signed [15:0] Hq_out_r, Hq_out_i;

    typedef int arr16_t[16];
    typedef int arr8_t[8];

    int exp_r_q[$];
    int exp_i_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_h_cyc = 0;
    int last_v_cyc = 0;
    bit first_pending = 1'b0;

    matrix_multiplier #(
        .Q         (8),
        .N         (16),
        .ACC_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .H_in_valid   (H_in_valid),
        .H_in_r       (H_in_r),
        .H_in_i       (H_in_i),
        .q_index      (q_index),
        .done         (done),
        .Hq_out_valid (Hq_out_valid),
        .Hq_out_r     (Hq_out_r),
        .Hq_out_i     (Hq_out_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pop and compare on every valid pulse, and check pulse timing
    always @(negedge clk) begin
        if (rst && Hq_out_valid) begin
            if (exp_r_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got (%0d,%0d), expected no output", Hq_out_r, Hq_out_i);
            end else begin
                check("hq_r", int'(Hq_out_r), exp_r_q.pop_front());
                check("hq_i", int'(Hq_out_i), exp_i_q.pop_front());
                if (first_pending) begin
                    check("first_latency", cyc - last_h_cyc, 5);
                    first_pending = 1'b0;
                end else begin
                    check("valid_spacing", cyc - last_v_cyc, 5);
                end
            end
            last_v_cyc = cyc;
        end
    end

    task automatic run_job(input int q, input arr16_t hr, input arr16_t hi,
                           input arr8_t er, input arr8_t ei,
                           input bit gaps, input bit junk_on_start, input bit mid_start);
        int t;
        for (int i = 0; i < 8; i++) begin
            exp_r_q.push_back(er[i]);
            exp_i_q.push_back(ei[i]);
        end
        first_pending = 1'b1;
        @(posedge clk); #1;
        start   = 1'b1;
        q_index = 4'(q);
        if (junk_on_start) begin
            H_in_valid = 1'b1;
            H_in_r     = 16'sh1234;
            H_in_i     = -16'sd5;
        end
        @(posedge clk); #1;
        start      = 1'b0;
        H_in_valid = 1'b0;
        q_index    = 4'hA;
        check("done_cleared_on_start", int'(done), 0);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    H_in_valid = 1'b0;
                    H_in_r     = 16'sh7777;
                    @(posedge clk); #1;
                end
            end
            H_in_valid = 1'b1;
            H_in_r     = 16'(hr[i]);
            H_in_i     = 16'(hi[i]);
            @(posedge clk); #1;
        end
        last_h_cyc = cyc;
        H_in_valid = 1'b0;
        if (mid_start) begin
            // stray H samples and a start pulse while computing must both be ignored
            H_in_valid = 1'b1;
            H_in_r     = 16'sh4000;
            repeat (3) begin @(posedge clk); #1; end
            H_in_valid = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            start   = 1'b1;
            q_index = 4'd1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got done=0, expected done=1 within 100 cycles");
        end else begin
            check("done_after_last_valid", cyc - last_v_cyc, 1);
            check("queue_drained", exp_r_q.size(), 0);
        end
        repeat (3) @(negedge clk);
        check("done_hold", int'(done), 1);
    endtask

    initial begin
        arr16_t h_id_r, h_zero, h_all256, h_sat;
        arr8_t  e_id_r, e_zero, e_col1_512, e_col1_sat;

        for (int i = 0; i < 16; i++) begin
            h_id_r[i]   = ((i / 4) == (i % 4)) ? 256 : 0;
            h_zero[i]   = 0;
            h_all256[i] = 256;
            h_sat[i]    = 32767;
        end
        e_id_r     = '{128, 128, -128, 128, 128, 128, -128, 128};
        e_zero     = '{0, 0, 0, 0, 0, 0, 0, 0};
        e_col1_512 = '{0, 512, 0, 512, 0, 512, 0, 512};
        e_col1_sat = '{0, 32767, 0, 32767, 0, 32767, 0, 32767};

        rst        = 1'b0;
        start      = 1'b0;
        H_in_valid = 1'b0;
        H_in_r     = '0;
        H_in_i     = '0;
        q_index    = '0;
        #1;
        check("reset_done", int'(done), 0);
        check("reset_valid", int'(Hq_out_valid), 0);
        check("reset_out_r", int'(Hq_out_r), 0);
        check("reset_out_i", int'(Hq_out_i), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_job(0, h_id_r, h_zero, e_id_r, e_zero, 1'b0, 1'b0, 1'b0);
        run_job(1, h_id_r, h_zero, e_zero, e_zero, 1'b0, 1'b0, 1'b0);
        run_job(0, h_all256, h_zero, e_col1_512, e_zero, 1'b0, 1'b1, 1'b0);
        run_job(0, h_zero, h_all256, e_zero, e_col1_512, 1'b0, 1'b0, 1'b0);
        run_job(0, h_sat, h_zero, e_col1_sat, e_zero, 1'b0, 1'b0, 1'b0);
        run_job(0, h_id_r, h_zero, e_id_r, e_zero, 1'b1, 1'b0, 1'b1);

        // Abort a job part-way through LOAD with an asynchronous reset
        @(posedge clk); #1;
        start   = 1'b1;
        q_index = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            H_in_valid = 1'b1;
            H_in_r     = 16'sd999;
            H_in_i     = -16'sd999;
            @(posedge clk); #1;
        end
        H_in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midload_reset_done", int'(done), 0);
        check("midload_reset_valid", int'(Hq_out_valid), 0);
        check("midload_reset_out_r", int'(Hq_out_r), 0);
        check("midload_reset_out_i", int'(Hq_out_i), 0);
        @(negedge clk);
        rst = 1'b1;

        run_job(0, h_id_r, h_zero, e_id_r, e_zero, 1'b0, 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        check("final_queue_empty", exp_r_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
